// File: rtl/uart_rx_frame.sv
// UART receive framer: synchronises the oversampled line, majority-votes each bit,
// deserialises LSB-first and reports each frame with a valid pulse plus parity/stop error flags.
module uart_rx_frame #(
  parameter int unsigned DATAWIDTH = 8,
  parameter int unsigned PRESCALE  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxIn,
  input  logic                 parityEnable,
  input  logic                 parityType,
  output logic [DATAWIDTH-1:0] dataOut,
  output logic                 dataValid,
  output logic                 parityError,
  output logic                 frameError,
  output logic                 busy
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned BW = $clog2(DATAWIDTH + 1);
  localparam logic [CW-1:0] SMP0 = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] SMP1 = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] VOTE = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 r_state;
  state_t                 w_state_nx;
  logic                   r_sync1;
  logic                   r_rxs;
  logic [CW-1:0]          r_cnt;
  logic [1:0]             r_smp;
  logic [BW-1:0]          r_bits;
  logic [DATAWIDTH-1:0]   r_shreg;
  logic                   r_pen;
  logic                   r_ptype;
  logic                   r_perr;
  logic [DATAWIDTH-1:0]   r_data;
  logic                   r_valid;
  logic                   r_perr_o;
  logic                   r_ferr;
  logic                   r_busy;
  logic                   w_vote;
  logic                   w_at_vote;
  logic                   w_at_last;

  assign w_at_vote = (r_cnt == VOTE);
  assign w_at_last = (r_cnt == LAST);
  assign w_vote    = (r_smp[0] & r_smp[1]) | (r_smp[0] & r_rxs) | (r_smp[1] & r_rxs);

  // Two-flop synchroniser; resets to the idle (high) level so reset release cannot look like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_rxs   <= 1'b1;
    end else begin
      r_sync1 <= rxIn;
      r_rxs   <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (!r_rxs) w_state_nx = START;
      START: begin
        if (w_at_vote && w_vote) w_state_nx = IDLE;
        else if (w_at_last)      w_state_nx = DATA;
      end
      DATA:    if (w_at_last && (r_bits == BW'(DATAWIDTH))) w_state_nx = r_pen ? PARITY : STOP;
      PARITY:  if (w_at_last) w_state_nx = STOP;
      STOP:    if (w_at_vote) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end

  // The IDLE cycle that first sees the low line counts as cnt=0 of the start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_smp    <= 2'b11;
      r_bits   <= '0;
      r_shreg  <= '0;
      r_pen    <= 1'b0;
      r_ptype  <= 1'b0;
      r_perr   <= 1'b0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_perr_o <= 1'b0;
      r_ferr   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_busy  <= (w_state_nx != IDLE);

      if (w_state_nx == IDLE)  r_cnt <= '0;
      else if (r_state == IDLE) r_cnt <= CW'(1);
      else if (w_at_last)      r_cnt <= '0;
      else                     r_cnt <= r_cnt + CW'(1);

      if (r_cnt == SMP0) r_smp[0] <= r_rxs;
      if (r_cnt == SMP1) r_smp[1] <= r_rxs;

      if (r_state == START && w_state_nx == DATA) begin
        r_pen   <= parityEnable;
        r_ptype <= parityType;
        r_bits  <= '0;
      end

      if (r_state == DATA && w_at_vote) begin
        r_shreg <= {w_vote, r_shreg[DATAWIDTH-1:1]};
        r_bits  <= r_bits + BW'(1);
      end

      if (r_state == PARITY && w_at_vote)
        r_perr <= w_vote ^ (r_ptype ? ~^r_shreg : ^r_shreg);

      if (r_state == STOP && w_at_vote) begin
        r_data   <= r_shreg;
        r_perr_o <= r_pen & r_perr;
        r_ferr   <= ~w_vote;
        r_valid  <= 1'b1;
      end
    end
  end

  assign dataOut     = r_data;
  assign dataValid   = r_valid;
  assign parityError = r_perr_o;
  assign frameError  = r_ferr;
  assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Bench for uart_rx_frame: directed and randomised frames on the serial line, scored against
// expectations derived from the frame contents (payload, parity rule, stop level, latency formula).
module tb_uart_rx_frame;

  localparam int unsigned DW  = 8;
  localparam int unsigned PS  = 8;
  localparam int unsigned LAT = 3 + PS / 2 + (DW + 1) * PS;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxIn = 1'b1;
  logic          parityEnable = 1'b0;
  logic          parityType = 1'b0;
  logic [DW-1:0] dataOut;
  logic          dataValid;
  logic          parityError;
  logic          frameError;
  logic          busy;

  int cyc = 0;
  int n_pass = 0;
  int n_chk = 0;

  typedef struct {int cyc; logic [7:0] d; logic pe; logic fe; logic bz;} obs_t;
  typedef struct {int cyc; logic [7:0] d; logic pe; logic fe;} exp_t;
  obs_t obs_q[$];
  exp_t exp_q[$];

  uart_rx_frame #(.DATAWIDTH(DW), .PRESCALE(PS)) dut (
    .clk(clk), .rst(rst), .rxIn(rxIn), .parityEnable(parityEnable), .parityType(parityType),
    .dataOut(dataOut), .dataValid(dataValid), .parityError(parityError),
    .frameError(frameError), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Every cycle with dataValid high is logged, so a stretched pulse shows up as an extra entry
  always @(negedge clk)
    if (dataValid === 1'b1) obs_q.push_back('{cyc, dataOut, parityError, frameError, busy});

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic send_bit(input logic b);
    rxIn = b;
    repeat (PS) @(negedge clk);
  endtask

  // Start bit is first sampled at the next posedge; parity config is scrambled after data bit 0
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic pty,
                            input logic pbit_ok, input logic stop);
    logic pbit;
    int   ones;
    ones = $countones(d);
    pbit = pty ? (ones % 2 == 0) : (ones % 2 == 1);
    if (!pbit_ok) pbit = ~pbit;
    parityEnable = pen;
    parityType   = pty;
    exp_q.push_back('{cyc + 1 + LAT + (pen ? PS : 0), d, pen & ~pbit_ok, ~stop});
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      send_bit(d[i]);
      if (i == 0) begin
        parityEnable = 1'($urandom);
        parityType   = 1'($urandom);
      end
    end
    if (pen) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic drain(input string tag);
    obs_t o;
    exp_t e;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_data"},    32'(o.d),  32'(e.d));
      chk({tag, "_perr"},    32'(o.pe), 32'(e.pe));
      chk({tag, "_ferr"},    32'(o.fe), 32'(e.fe));
      chk({tag, "_latency"}, o.cyc,     e.cyc);
      chk({tag, "_busy_lo"}, 32'(o.bz), 32'd0);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [7:0] rd;
    logic       rpen, rpty, rok, rstop, prev_stop;

    repeat (4) @(negedge clk);
    chk("rst_data",  32'(dataOut),     32'd0);
    chk("rst_valid", 32'(dataValid),   32'd0);
    chk("rst_perr",  32'(parityError), 32'd0);
    chk("rst_ferr",  32'(frameError),  32'd0);
    chk("rst_busy",  32'(busy),        32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("release_busy", 32'(busy), 32'd0);
    drain("release");

    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    drain("a5_even_ok");

    send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    drain("a5_even_bad");

    send_frame(8'h01, 1'b1, 1'b1, 1'b1, 1'b1);
    send_frame(8'h80, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    drain("b2b");

    send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0);
    rxIn = 1'b1;
    repeat (16) @(negedge clk);
    drain("ferr");

    prev_stop = 1'b1;
    for (int n = 0; n < 24; n++) begin
      rd    = 8'($urandom_range(0, 255));
      rpen  = 1'($urandom);
      rpty  = 1'($urandom);
      rok   = ($urandom_range(0, 3) != 0);
      rstop = ($urandom_range(0, 6) != 0);
      rxIn = 1'b1;
      repeat (prev_stop ? $urandom_range(0, 4) : 16) @(negedge clk);
      send_frame(rd, rpen, rpty, rok, rstop);
      prev_stop = rstop;
    end
    rxIn = 1'b1;
    repeat (16) @(negedge clk);
    drain("rand");

    rxIn = 1'b0;
    repeat (3) @(negedge clk);
    chk("glitch_busy_hi", 32'(busy), 32'd1);
    rxIn = 1'b1;
    repeat (PS) @(negedge clk);
    chk("glitch_busy_lo", 32'(busy), 32'd0);
    drain("glitch");

    send_frame(8'hC3, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    drain("pre_rst");

    parityEnable = 1'b0;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    rxIn = 1'b0;
    repeat (PS / 2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_data",  32'(dataOut),     32'd0);
    chk("midrst_valid", 32'(dataValid),   32'd0);
    chk("midrst_perr",  32'(parityError), 32'd0);
    chk("midrst_ferr",  32'(frameError),  32'd0);
    chk("midrst_busy",  32'(busy),        32'd0);
    rst  = 1'b1;
    rxIn = 1'b1;
    repeat (12) @(negedge clk);
    send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (4) @(negedge clk);
    drain("post_rst");

    repeat (8) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
